// File: rtl/basilisk_input_unpack_pkg.sv
// Shared definitions for the basilisk FPU input stage: fclass bit positions,
// the canonical NaN pattern and the unpacked-operand record for binary32.
package basilisk_input_unpack_pkg;

    localparam int FCLASS_W        = 10;
    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    // Canonical NaN: positive, significand {2'b11, 0...}
    localparam logic [1:0] CANON_NAN_MSBS = 2'b11;
    localparam logic       CANON_NAN_SIGN = 1'b0;

    localparam int EXP_WIDTH_DFLT  = 8;
    localparam int MANT_WIDTH_DFLT = 23;

    typedef struct packed {
        logic                              sign;
        logic signed [EXP_WIDTH_DFLT+1:0]  exp;
        logic        [MANT_WIDTH_DFLT:0]   mant;
        logic        [FCLASS_W-1:0]        fclass;
    } basilisk_unpacked_t;

endpackage

// File: rtl/basilisk_unpack_operand.sv
// Stateless unpack of one IEEE-754 operand: classify + LZC on the raw input,
// exponent/significand normalisation on the stage-1 registered copy.
module basilisk_unpack_operand
    import basilisk_input_unpack_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int CANON_NAN  = 1,
    localparam int W  = 1 + EXP_WIDTH + MANT_WIDTH,
    localparam int EW = EXP_WIDTH + 2,
    localparam int LW = $clog2(MANT_WIDTH + 1)
) (
    input  logic                 [W-1:0]        raw,
    output logic                 [LW-1:0]       lzc,
    output logic                 [FCLASS_W-1:0] fclass,
    output logic                                snan,
    input  logic                 [W-1:0]        raw_p1,
    input  logic                 [LW-1:0]       lzc_p1,
    output logic                                sign,
    output logic signed          [EW-1:0]       exp,
    output logic                 [MANT_WIDTH:0] mant
);

    localparam logic signed [EW-1:0] BIAS        = EW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_SPECIAL = BIAS + EW'(1);

    function automatic logic [LW-1:0] count_lz(input logic [MANT_WIDTH-1:0] f);
        count_lz = LW'(MANT_WIDTH);
        for (int i = 0; i < MANT_WIDTH; i++)
            if (f[i]) count_lz = LW'(MANT_WIDTH - 1 - i);
    endfunction

    logic                  s0;
    logic [EXP_WIDTH-1:0]  e0, e1;
    logic [MANT_WIDTH-1:0] f0, f1;

    assign s0 = raw[W-1];
    assign e0 = raw[W-2 -: EXP_WIDTH];
    assign f0 = raw[MANT_WIDTH-1:0];
    assign e1 = raw_p1[W-2 -: EXP_WIDTH];
    assign f1 = raw_p1[MANT_WIDTH-1:0];

    assign lzc = count_lz(f0);

    always_comb begin
        fclass = '0;
        snan   = 1'b0;
        if (&e0 && f0 != '0) begin
            if (f0[MANT_WIDTH-1]) begin
                fclass[FCLASS_QNAN] = 1'b1;
            end else begin
                fclass[FCLASS_SNAN] = 1'b1;
                snan                = 1'b1;
            end
        end else if (&e0)
            fclass[s0 ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
        else if (e0 == '0 && f0 == '0)
            fclass[s0 ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
        else if (e0 == '0)
            fclass[s0 ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
        else
            fclass[s0 ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    end

    // Subnormals: shift the fraction until its leading one reaches the significand MSB
    always_comb begin
        sign = raw_p1[W-1];
        exp  = '0;
        mant = '0;
        if (&e1) begin
            exp  = EXP_SPECIAL;
            mant = {1'b1, f1};
            if (f1 != '0 && CANON_NAN != 0) begin
                sign = CANON_NAN_SIGN;
                mant = {CANON_NAN_MSBS, {(MANT_WIDTH - 1){1'b0}}};
            end
        end else if (e1 == '0) begin
            if (f1 != '0) begin
                exp  = -BIAS - $signed({{(EW - LW){1'b0}}, lzc_p1});
                mant = {f1, 1'b0} << lzc_p1;
            end
        end else begin
            exp  = $signed({2'b00, e1}) - BIAS;
            mant = {1'b1, f1};
        end
    end

endmodule

// File: rtl/basilisk_input_unpack.sv
// basilisk FPU input stage: two-stage operand unpack pipeline feeding a
// credit-protected output FIFO so execute units may stall without backpressure upstream.
module basilisk_input_unpack
    import basilisk_input_unpack_pkg::*;
#(
    parameter int OPERANDS     = 3,
    parameter int EXP_WIDTH    = 8,
    parameter int MANT_WIDTH   = 23,
    parameter int TAG_WIDTH    = 5,
    parameter int BUFFER_DEPTH = 4,
    parameter int CANON_NAN    = 1,
    localparam int W  = 1 + EXP_WIDTH + MANT_WIDTH,
    localparam int EW = EXP_WIDTH + 2,
    localparam int MW = MANT_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4:0]                     in_op,
    input  logic [2:0]                     in_rm,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    input  logic [OPERANDS*W-1:0]          in_operands,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4:0]                     out_op,
    output logic [2:0]                     out_rm,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic [OPERANDS-1:0]            out_sign,
    output logic [OPERANDS*EW-1:0]         out_exp,
    output logic [OPERANDS*MW-1:0]         out_mant,
    output logic [OPERANDS*FCLASS_W-1:0]   out_class,
    output logic                           out_invalid
);

    localparam int LW    = $clog2(MANT_WIDTH + 1);
    localparam int PW    = $clog2(BUFFER_DEPTH);
    localparam int CW    = $clog2(BUFFER_DEPTH + 1);
    localparam int PAY_W = 5 + 3 + TAG_WIDTH + 1 + OPERANDS * (1 + EW + MW + FCLASS_W);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [OPERANDS*LW-1:0]       lzc_p0;
    logic [OPERANDS*FCLASS_W-1:0] class_p0;
    logic [OPERANDS-1:0]          snan_p0;
    logic                         accept;

    logic                         vld_p1, invalid_p1;
    logic [4:0]                   op_p1;
    logic [2:0]                   rm_p1;
    logic [TAG_WIDTH-1:0]         tag_p1;
    logic [OPERANDS*W-1:0]        raw_p1;
    logic [OPERANDS*LW-1:0]       lzc_p1;
    logic [OPERANDS*FCLASS_W-1:0] class_p1;

    logic [OPERANDS-1:0]          sign_c;
    logic [OPERANDS*EW-1:0]       exp_c;
    logic [OPERANDS*MW-1:0]       mant_c;

    logic                         vld_p2, invalid_p2;
    logic [4:0]                   op_p2;
    logic [2:0]                   rm_p2;
    logic [TAG_WIDTH-1:0]         tag_p2;
    logic [OPERANDS-1:0]          sign_p2;
    logic [OPERANDS*EW-1:0]       exp_p2;
    logic [OPERANDS*MW-1:0]       mant_p2;
    logic [OPERANDS*FCLASS_W-1:0] class_p2;

    logic [PAY_W-1:0]             mem [BUFFER_DEPTH];
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count;
    logic [CW:0]                  pending;
    logic                         ready_en, enq, deq;

    for (genvar i = 0; i < OPERANDS; i++) begin : g_operand
        basilisk_unpack_operand #(
            .EXP_WIDTH  (EXP_WIDTH),
            .MANT_WIDTH (MANT_WIDTH),
            .CANON_NAN  (CANON_NAN)
        ) u_unpack (
            .raw    (in_operands[i*W +: W]),
            .lzc    (lzc_p0[i*LW +: LW]),
            .fclass (class_p0[i*FCLASS_W +: FCLASS_W]),
            .snan   (snan_p0[i]),
            .raw_p1 (raw_p1[i*W +: W]),
            .lzc_p1 (lzc_p1[i*LW +: LW]),
            .sign   (sign_c[i]),
            .exp    (exp_c[i*EW +: EW]),
            .mant   (mant_c[i*MW +: MW])
        );
    end

    // Credit counts every command already committed to a FIFO slot, so the FIFO never overflows
    assign pending  = {1'b0, count} + (CW + 1)'(vld_p1) + (CW + 1)'(vld_p2);
    assign in_ready = ready_en && (pending < (CW + 1)'(BUFFER_DEPTH));
    assign accept   = in_valid && in_ready;

    // Stage 1: raw fields, class and leading-zero count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            invalid_p1 <= 1'b0;
            op_p1      <= '0;
            rm_p1      <= '0;
            tag_p1     <= '0;
            raw_p1     <= '0;
            lzc_p1     <= '0;
            class_p1   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                invalid_p1 <= |snan_p0;
                op_p1      <= in_op;
                rm_p1      <= in_rm;
                tag_p1     <= in_tag;
                raw_p1     <= in_operands;
                lzc_p1     <= lzc_p0;
                class_p1   <= class_p0;
            end
        end
    end

    // Stage 2: normalised sign / exponent / significand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2     <= 1'b0;
            invalid_p2 <= 1'b0;
            op_p2      <= '0;
            rm_p2      <= '0;
            tag_p2     <= '0;
            sign_p2    <= '0;
            exp_p2     <= '0;
            mant_p2    <= '0;
            class_p2   <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                invalid_p2 <= invalid_p1;
                op_p2      <= op_p1;
                rm_p2      <= rm_p1;
                tag_p2     <= tag_p1;
                sign_p2    <= sign_c;
                exp_p2     <= exp_c;
                mant_p2    <= mant_c;
                class_p2   <= class_p1;
            end
        end
    end

    assign enq       = vld_p2;
    assign out_valid = (count != '0);
    assign deq       = out_valid && out_ready;

    // Output FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
            for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            if (enq) begin
                mem[wr_ptr] <= {op_p2, rm_p2, tag_p2, invalid_p2, sign_p2, exp_p2, mant_p2, class_p2};
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (deq) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign {out_op, out_rm, out_tag, out_invalid, out_sign, out_exp, out_mant, out_class} = mem[rd_ptr];

endmodule
